wb_mixer_arb: RTL and testbench
===============================

// Module: wb_mixer_arb
// PURPOSE
//  Parametrised N-channel Wishbone master mixer with a built-in round-robin arbiter.
//  It merges NCH internal DMA/engine masters onto one Wishbone master port.
//  Arbitration, grant hold and release, and response steering are all internal; no external gnt is required.
//  It sits between the channel engines and the system-bus bridge.
// PARAMETERS
//  NCH      5    number of slave-side channels (2..16)
//  AW       32   address width
//  DW       64   data width; a 64-bit bus replaces the separate dat/dat64 lanes
//  SW       DW/8 byte-select width
//  TO_CYC   255  watchdog limit in cycles (used only with WB_MIXER_TIMEOUT_EN)
// PORTS
//  wb_clk_i     in   1        bus clock
//  wb_rst_i     in   1        reset, asynchronous, active-low
//  wbs_cyc_i    in   NCH      per-channel cyc
//  wbs_stb_i    in   NCH      per-channel stb
//  wbs_we_i     in   NCH      per-channel we
//  wbs_cab_i    in   NCH      per-channel cab (burst)
//  wbs_sel_i    in   NCH*SW   per-channel sel; channel k occupies [k*SW +: SW]
//  wbs_adr_i    in   NCH*AW   per-channel address
//  wbs_dat_i    in   NCH*DW   per-channel write data
//  wbs_dat_o    out  DW       read data, broadcast to all channels
//  wbs_ack_o    out  NCH      ack, steered to the owner only
//  wbs_err_o    out  NCH      err, steered to the owner only
//  wbs_rty_o    out  NCH      rty, steered to the owner only
//  wbm_cyc_o    out  1        master cyc
//  wbm_stb_o    out  1        master stb
//  wbm_we_o     out  1        master we
//  wbm_cab_o    out  1        master cab
//  wbm_sel_o    out  SW       master sel
//  wbm_adr_o    out  AW       master address
//  wbm_dat_o    out  DW       master write data
//  wbm_ack_i    in   1        master ack
//  wbm_err_i    in   1        master err
//  wbm_rty_i    in   1        master rty
//  wbm_dat_i    in   DW       master read data
//  gnt_o        out  NCH      one-hot current owner, for debug and status
// BEHAVIOUR
//  - Reset: state=IDLE, gnt_o=0, last-owner pointer=NCH-1, so channel 0 wins first.
//    All wbm_*_o=0 and all wbs_ack/err/rty_o=0.
//  - FSM states: IDLE, OWN.
//    IDLE: if any wbs_cyc_i is high, register a one-hot grant to the first requester after the last owner, cyclically.
//    Enter OWN on that edge.
//  - Grant latency: 1 cycle from cyc to wbm_cyc_o.
//  - OWN: gnt_o is held while the owner's cyc is high.
//    Requests from other channels never pre-empt the owner, including cab bursts.
//  - Release: when the owner's cyc falls, clear gnt_o and go to IDLE on the same edge.
//    This gives a one-cycle bubble between owners, and the owner pointer updates on that edge.
//  - Master outputs: combinational AND-OR mux of channel signals, selected by registered gnt_o.
//    With gnt_o=0, all master outputs are 0.
//  - Responses: wbs_x_o[k] = wbm_x_i & gnt_o[k]. This is zero-latency with no registering.
//  - wbs_dat_o = wbm_dat_i, unqualified.
//  - Simultaneous requests are resolved strictly round-robin; no channel waits more than NCH-1 tenures.
//  - If the owner drops cyc in the same cycle a response arrives, the response is still steered to it.
//  - Reset during OWN: the bus is abandoned immediately and all outputs are 0 asynchronously.
// CONFIGURATION
//  WB_MIXER_TIMEOUT_EN defined:
//   - A counter counts cycles with wbm_stb_o=1 and no ack/err/rty; it clears on any response or on a grant change.
//   - When it reaches TO_CYC: pulse wbs_err_o[owner] for 1 cycle, force wbm_cyc_o/wbm_stb_o to 0, and clear the grant.
//     The FSM enters IDLE, and the channel must drop cyc before it can be re-granted.
//  WB_MIXER_TIMEOUT_EN not defined:
//   - No counter; a stalled slave holds the bus indefinitely. TO_CYC is ignored.
// STRUCTURE
//  - Package wb_mixer_pkg holds:
//    - state encoding constants ST_IDLE and ST_OWN
//    - a clog2 function for the owner-pointer width
//    - the TO_CYC counter width
//  - Sub-module rr_pick: combinational round-robin next-owner select (req[NCH], last[log2 NCH] -> one-hot).
//  - The FSM, muxes and watchdog live in wb_mixer_arb.
// TESTING
//  1. Reset with cyc_i=5'b10110 -> after release, gnt_o=5'b00010 on the first clk; wbm_adr_o=adr ch1.
//  2. ch1 burst of 4 acks with ch3 requesting throughout -> ch3 is not granted until ch1 drops cyc.
//     gnt_o=0 for exactly 1 cycle, then gnt_o=5'b01000.
//  3. All 5 channels hold cyc and do 1-ack transfers -> grant order 0,1,2,3,4,0; no starvation.
//  4. Owner ch2 with wbm_err_i=1 -> wbs_err_o=5'b00100 only; wbm_rty_i=1 -> wbs_rty_o=5'b00100.
//  5. Reset asserted mid-OWN (ch4 granted) -> wbm_cyc_o=0 and gnt_o=0 immediately, without waiting for clk.
//  6. TIMEOUT_EN, TO_CYC=8, no ack -> wbs_err_o[owner] pulses at stb cycle 8, then wbm_cyc_o=0.
//     Without the macro, cyc stays high for 1000 cycles.

Source files
------------

// File: rtl/wb_mixer_pkg.sv
// Shared types and constants for the wb_mixer_arb Wishbone mixer.
// State encoding, pointer-width helper and watchdog counter width.
package wb_mixer_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } state_t;

  // Watchdog counter width; TO_CYC must fit in this many bits.
  localparam int TO_CW = 16;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/wb_mixer_arb_rr_pick.sv
// Round-robin next-owner select: first requester strictly after 'last',
// searching cyclically, returned one-hot (all zero when nothing requests).
module rr_pick
  import wb_mixer_pkg::*;
#(
  parameter int NCH = 5,
  parameter int PW  = clog2(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [PW-1:0]  last,
  output logic [NCH-1:0] pick
);

  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= NCH; i++) begin
      idx = PW'((int'(last) + i) % NCH);
      if (!found && req[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_mixer_arb.sv
// N-channel Wishbone master mixer with round-robin arbitration and response steering.
// Optional watchdog compiled in with WB_MIXER_TIMEOUT_EN.
module wb_mixer_arb
  import wb_mixer_pkg::*;
#(
  parameter int NCH    = 5,
  parameter int AW     = 32,
  parameter int DW     = 64,
  parameter int SW     = DW / 8,
  parameter int TO_CYC = 255
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic [NCH-1:0]    wbs_cyc_i,
  input  logic [NCH-1:0]    wbs_stb_i,
  input  logic [NCH-1:0]    wbs_we_i,
  input  logic [NCH-1:0]    wbs_cab_i,
  input  logic [NCH*SW-1:0] wbs_sel_i,
  input  logic [NCH*AW-1:0] wbs_adr_i,
  input  logic [NCH*DW-1:0] wbs_dat_i,
  output logic [DW-1:0]     wbs_dat_o,
  output logic [NCH-1:0]    wbs_ack_o,
  output logic [NCH-1:0]    wbs_err_o,
  output logic [NCH-1:0]    wbs_rty_o,
  output logic              wbm_cyc_o,
  output logic              wbm_stb_o,
  output logic              wbm_we_o,
  output logic              wbm_cab_o,
  output logic [SW-1:0]     wbm_sel_o,
  output logic [AW-1:0]     wbm_adr_o,
  output logic [DW-1:0]     wbm_dat_o,
  input  logic              wbm_ack_i,
  input  logic              wbm_err_i,
  input  logic              wbm_rty_i,
  input  logic [DW-1:0]     wbm_dat_i,
  output logic [NCH-1:0]    gnt_o
);

  // state   | meaning
  // ST_IDLE | no owner; next edge grants the round-robin pick, if any
  // ST_OWN  | gnt_q holds the owner until its cyc falls (or watchdog fires)

  localparam int PW = clog2(NCH);

  state_t         state_q, state_d;
  logic [NCH-1:0] gnt_q, gnt_d;
  logic [PW-1:0]  last_q, last_d;
  logic [PW-1:0]  owner_idx;
  logic           owner_cyc;
  logic [NCH-1:0] blk_q;
  logic [NCH-1:0] req_ok;
  logic [NCH-1:0] pick;
  logic           to_hit;

  always_comb begin
    owner_idx = '0;
    for (int k = 0; k < NCH; k++) begin
      if (gnt_q[k]) owner_idx = PW'(k);
    end
  end

  assign owner_cyc = |(gnt_q & wbs_cyc_i);
  assign req_ok    = wbs_cyc_i & ~blk_q;

  rr_pick #(
    .NCH (NCH),
    .PW  (PW)
  ) u_pick (
    .req  (req_ok),
    .last (last_q),
    .pick (pick)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (|req_ok) begin
          gnt_d   = pick;
          state_d = ST_OWN;
        end
      end
      ST_OWN: begin
        if (!owner_cyc || to_hit) begin
          gnt_d   = '0;
          state_d = ST_IDLE;
          last_d  = owner_idx;
        end
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      last_q  <= PW'(NCH - 1);
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
    end
  end

  // AND-OR mux: with no grant every master output collapses to zero.
  always_comb begin
    wbm_cyc_o = 1'b0;
    wbm_stb_o = 1'b0;
    wbm_we_o  = 1'b0;
    wbm_cab_o = 1'b0;
    wbm_sel_o = '0;
    wbm_adr_o = '0;
    wbm_dat_o = '0;
    for (int k = 0; k < NCH; k++) begin
      wbm_cyc_o = wbm_cyc_o | (gnt_q[k] & wbs_cyc_i[k]);
      wbm_stb_o = wbm_stb_o | (gnt_q[k] & wbs_stb_i[k]);
      wbm_we_o  = wbm_we_o  | (gnt_q[k] & wbs_we_i[k]);
      wbm_cab_o = wbm_cab_o | (gnt_q[k] & wbs_cab_i[k]);
      wbm_sel_o = wbm_sel_o | (wbs_sel_i[k*SW +: SW] & {SW{gnt_q[k]}});
      wbm_adr_o = wbm_adr_o | (wbs_adr_i[k*AW +: AW] & {AW{gnt_q[k]}});
      wbm_dat_o = wbm_dat_o | (wbs_dat_i[k*DW +: DW] & {DW{gnt_q[k]}});
    end
  end

  assign wbs_dat_o = wbm_dat_i;
  assign wbs_ack_o = gnt_q & {NCH{wbm_ack_i}};
  assign wbs_err_o = gnt_q & {NCH{wbm_err_i | to_hit}};
  assign wbs_rty_o = gnt_q & {NCH{wbm_rty_i}};
  assign gnt_o     = gnt_q;

`ifdef WB_MIXER_TIMEOUT_EN
  localparam logic [TO_CW-1:0] TO_LAST = TO_CW'(TO_CYC - 1);

  logic [TO_CW-1:0] to_cnt_q;
  logic             resp;
  logic             stall;

  assign resp   = wbm_ack_i | wbm_err_i | wbm_rty_i;
  assign stall  = wbm_stb_o & ~resp;
  assign to_hit = stall && (to_cnt_q == TO_LAST);

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      to_cnt_q <= '0;
    end else if (resp || (gnt_d != gnt_q)) begin
      to_cnt_q <= '0;
    end else if (stall) begin
      to_cnt_q <= to_cnt_q + 1'b1;
    end
  end

  // A timed-out channel stays locked out until it drops its cyc.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      blk_q <= '0;
    end else begin
      blk_q <= (blk_q & wbs_cyc_i) | (to_hit ? gnt_q : '0);
    end
  end
`else
  // Always low when the watchdog is compiled out.
  assign to_hit = (TO_CYC < 0);
  assign blk_q  = '0;
`endif

endmodule

// File: tb/tb_wb_mixer_arb.sv
// Scoreboard bench for wb_mixer_arb: grants and responses are checked by a monitor.
module tb_wb_mixer_arb;

  localparam int NCH = 5;
  localparam int AW  = 32;
  localparam int DW  = 64;
  localparam int SW  = 8;

  logic              clk;
  logic              rst_n;
  logic [NCH-1:0]    cyc, stb, we, cab;
  logic [NCH*SW-1:0] sel;
  logic [NCH*AW-1:0] adr;
  logic [NCH*DW-1:0] dat;
  logic [DW-1:0]     wbs_dat_o;
  logic [NCH-1:0]    ack_o, err_o, rty_o;
  logic              m_cyc, m_stb, m_we, m_cab;
  logic [SW-1:0]     m_sel;
  logic [AW-1:0]     m_adr;
  logic [DW-1:0]     m_dat;
  logic              ack_i, err_i, rty_i;
  logic [DW-1:0]     m_dat_i;
  logic [NCH-1:0]    gnt_o;

  int checks = 0;
  int failures = 0;

  logic [NCH-1:0]   gq[$];
  logic [AW-1:0]    aq[$];
  logic [3*NCH-1:0] rq[$];

  logic [AW-1:0] ADR [NCH] = '{32'h1000_0000, 32'h1000_0010, 32'h1000_0020,
                               32'h1000_0030, 32'h1000_0040};

  wb_mixer_arb #(.NCH(NCH), .AW(AW), .DW(DW), .SW(SW), .TO_CYC(8)) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst_n),
    .wbs_cyc_i (cyc),
    .wbs_stb_i (stb),
    .wbs_we_i  (we),
    .wbs_cab_i (cab),
    .wbs_sel_i (sel),
    .wbs_adr_i (adr),
    .wbs_dat_i (dat),
    .wbs_dat_o (wbs_dat_o),
    .wbs_ack_o (ack_o),
    .wbs_err_o (err_o),
    .wbs_rty_o (rty_o),
    .wbm_cyc_o (m_cyc),
    .wbm_stb_o (m_stb),
    .wbm_we_o  (m_we),
    .wbm_cab_o (m_cab),
    .wbm_sel_o (m_sel),
    .wbm_adr_o (m_adr),
    .wbm_dat_o (m_dat),
    .wbm_ack_i (ack_i),
    .wbm_err_i (err_i),
    .wbm_rty_i (rty_i),
    .wbm_dat_i (m_dat_i),
    .gnt_o     (gnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_gnt(input int k);
    gq.push_back(NCH'(1) << k);
    aq.push_back(ADR[k]);
  endtask

  // expected {ack, err, rty} one-hot vectors
  task automatic push_resp(input logic [NCH-1:0] a, input logic [NCH-1:0] e, input logic [NCH-1:0] r);
    rq.push_back({a, e, r});
  endtask

  task automatic wait_gnt(input logic [NCH-1:0] e);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (gnt_o !== e && n < 40);
    if (gnt_o !== e) begin
      checks++;
      failures++;
      $display("FAIL wait_gnt timeout: got %0h expected %0h", gnt_o, e);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops expectations whenever a response or a fresh grant appears.
  initial begin : monitor
    logic [NCH-1:0]   prev;
    logic [3*NCH-1:0] r, e;
    prev = '0;
    forever begin
      @(negedge clk);
      r = {ack_o, err_o, rty_o};
      if (r != '0) begin
        if (rq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_resp: got %0h expected none", r);
        end else begin
          e = rq.pop_front();
          chk("resp", 64'(r), 64'(e));
        end
      end
      if (gnt_o != '0 && prev == '0) begin
        if (gq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_gnt: got %0h expected none", gnt_o);
        end else begin
          chk("gnt", 64'(gnt_o), 64'(gq.pop_front()));
          chk("gnt_adr", 64'(m_adr), 64'(aq.pop_front()));
        end
      end
      prev = gnt_o;
    end
  end

  int order [6] = '{0, 1, 2, 3, 4, 0};

  initial begin : stim
    int bad;
    rst_n = 1'b0;
    cyc = 5'b10110; stb = 5'b10110; we = '0; cab = '0;
    sel = '0; dat = '0; adr = '0;
    ack_i = 1'b0; err_i = 1'b0; rty_i = 1'b0;
    m_dat_i = '0;
    for (int k = 0; k < NCH; k++) adr[k*AW +: AW] = ADR[k];

    // 1: reset state, then ch1 wins first (pointer starts at NCH-1)
    #12;
    chk("rst_gnt", 64'(gnt_o), 64'h0);
    chk("rst_cyc", 64'(m_cyc), 64'h0);
    chk("rst_adr", 64'(m_adr), 64'h0);
    chk("rst_resp", 64'({ack_o, err_o, rty_o}), 64'h0);
    push_gnt(1);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("first_gnt", 64'(gnt_o), 64'h02);
    step;
    cyc = '0; stb = '0;
    repeat (3) step;

    // 2: ch1 cab burst of 4 acks, ch3 waits, then one-cycle bubble
    push_gnt(1);
    push_gnt(3);
    cyc[1] = 1'b1; stb[1] = 1'b1; cab[1] = 1'b1;
    wait_gnt(5'b00010);
    step;
    cyc[3] = 1'b1; stb[3] = 1'b1;
    repeat (4) push_resp(5'b00010, '0, '0);
    ack_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("burst_hold", 64'(gnt_o), 64'h02);
      chk("burst_cab", 64'(m_cab), 64'h1);
    end
    step;
    ack_i = 1'b0; cyc[1] = 1'b0; stb[1] = 1'b0; cab[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("bubble", 64'(gnt_o), 64'h0);
    @(negedge clk);
    chk("after_bubble", 64'(gnt_o), 64'h08);
    step;
    cyc = '0; stb = '0;
    repeat (3) step;

    // 3: fresh reset, all channels request -> 0,1,2,3,4,0
    rst_n = 1'b0;
    #1;
    chk("rst2_gnt", 64'(gnt_o), 64'h0);
    #10 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      push_gnt(order[i]);
      push_resp(NCH'(1) << order[i], '0, '0);
    end
    cyc = 5'b11111; stb = 5'b11111;
    for (int i = 0; i < 6; i++) begin
      wait_gnt(NCH'(1) << order[i]);
      step;
      ack_i = 1'b1;
      step;
      ack_i = 1'b0;
      cyc[order[i]] = 1'b0;
      step;
      if (i < 5) cyc[order[i]] = 1'b1;
    end
    cyc = '0; stb = '0;
    repeat (3) step;

    // 4: owner ch2, steering of err/rty/ack and data paths
    push_gnt(2);
    cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1;
    sel[2*SW +: SW] = 8'hA5;
    dat[2*DW +: DW] = 64'h0123_4567_89AB_CDEF;
    m_dat_i = 64'hFEED_FACE_0000_1234;
    wait_gnt(5'b00100);
    chk("m_we", 64'(m_we), 64'h1);
    chk("m_sel", 64'(m_sel), 64'hA5);
    chk("m_dat", m_dat, 64'h0123_4567_89AB_CDEF);
    chk("s_dat", wbs_dat_o, 64'hFEED_FACE_0000_1234);
    push_resp('0, 5'b00100, '0);
    step; err_i = 1'b1;
    step; err_i = 1'b0;
    push_resp('0, '0, 5'b00100);
    rty_i = 1'b1;
    step; rty_i = 1'b0;
    // owner drops cyc in the same cycle as its ack
    push_resp(5'b00100, '0, '0);
    ack_i = 1'b1; cyc[2] = 1'b0; stb[2] = 1'b0; we[2] = 1'b0;
    step; ack_i = 1'b0;
    repeat (3) step;

    // 6: stalled slave on ch3
    push_gnt(3);
`ifdef WB_MIXER_TIMEOUT_EN
    push_resp('0, 5'b01000, '0);
`endif
    cyc[3] = 1'b1; stb[3] = 1'b1;
    wait_gnt(5'b01000);
`ifdef WB_MIXER_TIMEOUT_EN
    repeat (7) @(negedge clk);
    @(negedge clk);
    chk("to_cyc", 64'(m_cyc), 64'h0);
    chk("to_gnt", 64'(gnt_o), 64'h0);
    repeat (5) @(negedge clk);
    chk("to_locked", 64'(gnt_o), 64'h0);
    step;
    cyc[3] = 1'b0; stb[3] = 1'b0;
`else
    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (m_cyc !== 1'b1) bad++;
    end
    chk("stall_hold", 64'(bad), 64'h0);
    step;
    cyc[3] = 1'b0; stb[3] = 1'b0;
`endif
    repeat (3) step;

    // 5: asynchronous reset during ch4 ownership
    push_gnt(4);
    cyc[4] = 1'b1; stb[4] = 1'b1;
    wait_gnt(5'b10000);
    #2 rst_n = 1'b0;
    #1;
    chk("async_cyc", 64'(m_cyc), 64'h0);
    chk("async_stb", 64'(m_stb), 64'h0);
    chk("async_gnt", 64'(gnt_o), 64'h0);
    #10;
    cyc = '0; stb = '0;
    rst_n = 1'b1;
    repeat (3) step;

    chk("gnt_queue_empty", 64'(gq.size()), 64'h0);
    chk("resp_queue_empty", 64'(rq.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
